// File: rtl/gpio_event_controller.sv
// gpio_event_controller: memory-mapped GPIO input block.
// Pins pass through a 2-flop synchronizer and a per-pin debounce filter.
// Filtered edges set sticky PENDING bits, which drive a maskable level irq.
// Registers are word-addressed: VALUE, RISE_EN, FALL_EN, PENDING (W1C),
// MASK and DEBOUNCE.
module gpio_event_controller #(
  parameter int          GPIO_PINS  = 13,
  parameter logic [31:0] ADDRESS    = 32'h6001_0000,
  parameter int          DB_W       = 16,
  parameter int          DB_DEFAULT = 1000
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic                 data_rw,
  input  logic                 data_cs,
  input  logic [29:0]          data_address,
  inout  wire  [31:0]          data_bus,
  input  logic [GPIO_PINS-1:0] gpio,
  output logic                 irq
);

  localparam logic [29:0] BASE_WORD   = ADDRESS[31:2];
  localparam logic [2:0]  OFF_VALUE   = 3'd0;
  localparam logic [2:0]  OFF_RISE_EN = 3'd1;
  localparam logic [2:0]  OFF_FALL_EN = 3'd2;
  localparam logic [2:0]  OFF_PENDING = 3'd3;
  localparam logic [2:0]  OFF_MASK    = 3'd4;
  localparam logic [2:0]  OFF_DEBOUNCE = 3'd5;

  logic [GPIO_PINS-1:0] s1_r;
  logic [GPIO_PINS-1:0] s2_r;
  logic [GPIO_PINS-1:0] stable_r;
  logic [DB_W-1:0]      cnt_r [GPIO_PINS];
  logic [GPIO_PINS-1:0] rise_en_r;
  logic [GPIO_PINS-1:0] fall_en_r;
  logic [GPIO_PINS-1:0] pending_r;
  logic [GPIO_PINS-1:0] mask_r;
  logic [DB_W-1:0]      debounce_r;

  logic [29:0]          rel_addr_s;
  logic [2:0]           off_s;
  logic                 sel_s;
  logic                 wr_s;
  logic                 rd_s;
  logic [31:0]          rdata_s;
  logic [GPIO_PINS-1:0] upd_s;
  logic [GPIO_PINS-1:0] rise_s;
  logic [GPIO_PINS-1:0] fall_s;
  logic [GPIO_PINS-1:0] w1c_s;
  logic                 unused_bus_s;

  // Address decode: the subtraction wraps, so addresses below the base never select.
  assign rel_addr_s = data_address - BASE_WORD;
  assign off_s      = rel_addr_s[2:0];
  assign sel_s      = data_cs && (rel_addr_s < 30'd8);
  assign wr_s       = sel_s && data_rw;
  assign rd_s       = sel_s && !data_rw;

  // Upper bus bits are ignored on write.
  assign unused_bus_s = ^data_bus;

  // A pin commits when it has disagreed with stable for DEBOUNCE+1 consecutive samples.
  always_comb begin
    upd_s = '0;
    for (int i = 0; i < GPIO_PINS; i++) begin
      upd_s[i] = (s2_r[i] != stable_r[i]) && (cnt_r[i] == debounce_r);
    end
  end

  assign rise_s = upd_s & s2_r & rise_en_r;
  assign fall_s = upd_s & ~s2_r & fall_en_r;
  assign w1c_s  = (wr_s && (off_s == OFF_PENDING)) ? data_bus[GPIO_PINS-1:0] : '0;

  // Read mux, zero-extended; offsets 6 and 7 read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_VALUE:    rdata_s[GPIO_PINS-1:0] = stable_r;
      OFF_RISE_EN:  rdata_s[GPIO_PINS-1:0] = rise_en_r;
      OFF_FALL_EN:  rdata_s[GPIO_PINS-1:0] = fall_en_r;
      OFF_PENDING:  rdata_s[GPIO_PINS-1:0] = pending_r;
      OFF_MASK:     rdata_s[GPIO_PINS-1:0] = mask_r;
      OFF_DEBOUNCE: rdata_s[DB_W-1:0]      = debounce_r;
      default:      rdata_s = 32'd0;
    endcase
  end

  assign data_bus = rd_s ? rdata_s : 32'bz;

  assign irq = |(pending_r & mask_r);

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= gpio;
      s2_r <= s1_r;
    end
  end

  // Per-pin debounce counters and the filtered pin state.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stable_r <= '0;
      for (int i = 0; i < GPIO_PINS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < GPIO_PINS; i++) begin
        if (s2_r[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (upd_s[i]) begin
          stable_r[i] <= s2_r[i];
          cnt_r[i]    <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rise_en_r  <= '0;
      fall_en_r  <= '0;
      mask_r     <= '0;
      debounce_r <= DB_W'(DB_DEFAULT);
    end else if (wr_s) begin
      case (off_s)
        OFF_RISE_EN:  rise_en_r  <= data_bus[GPIO_PINS-1:0];
        OFF_FALL_EN:  fall_en_r  <= data_bus[GPIO_PINS-1:0];
        OFF_MASK:     mask_r     <= data_bus[GPIO_PINS-1:0];
        OFF_DEBOUNCE: debounce_r <= data_bus[DB_W-1:0];
        default:      ;
      endcase
    end
  end

  // Sticky pending bits: a new event on the clearing edge wins over the clear.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~w1c_s) | rise_s | fall_s;
    end
  end

endmodule

// File: tb/tb_gpio_event_controller.sv
// Directed bench for gpio_event_controller: a register-access vector table
// plus hand-timed sequences for debounce latency, glitches, W1C and masking.
module tb_gpio_event_controller;

  localparam int          PINS   = 13;
  localparam logic [29:0] BASE_W = 30'h1800_4000;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic        data_rw;
  logic        data_cs;
  logic [29:0] data_address;
  wire  [31:0] data_bus;
  logic [PINS-1:0] gpio;
  logic        irq;

  logic        tb_drv;
  logic [31:0] tb_wdata;

  int checks;
  int failures;

  typedef struct {
    logic        wr;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [21];

  assign data_bus = tb_drv ? tb_wdata : 32'bz;

  gpio_event_controller #(
    .GPIO_PINS  (PINS),
    .ADDRESS    (32'h6001_0000),
    .DB_W       (16),
    .DB_DEFAULT (1000)
  ) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_n    (cpu_rst_n),
    .data_rw      (data_rw),
    .data_cs      (data_cs),
    .data_address (data_address),
    .data_bus     (data_bus),
    .gpio         (gpio),
    .irq          (irq)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  // Combinational read, sampled 1 time unit after the request; no clock edge is consumed.
  task automatic bus_read(input logic [2:0] off, output logic [31:0] val);
    tb_drv       = 1'b0;
    data_cs      = 1'b1;
    data_rw      = 1'b0;
    data_address = BASE_W + 30'(off);
    #1;
    val     = data_bus;
    data_cs = 1'b0;
  endtask

  // Write spanning exactly one rising edge; returns on the following falling edge.
  task automatic bus_write(input logic [2:0] off, input logic [31:0] val);
    tb_drv       = 1'b1;
    tb_wdata     = val;
    data_cs      = 1'b1;
    data_rw      = 1'b1;
    data_address = BASE_W + 30'(off);
    @(negedge cpu_clk);
    data_cs = 1'b0;
    data_rw = 1'b0;
    tb_drv  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(off, v);
    check(name, v, exp);
  endtask

  // Bench holds the bus at zero; any DUT drive of a nonzero register disturbs it.
  task automatic quiet_probe(input string name, input logic cs, input logic rw, input logic [29:0] addr);
    tb_drv       = 1'b1;
    tb_wdata     = 32'h0;
    data_cs      = cs;
    data_rw      = rw;
    data_address = addr;
    #1;
    check(name, data_bus, 32'h0);
    data_cs = 1'b0;
    data_rw = 1'b0;
    tb_drv  = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cpu_rst_n    = 1'b0;
    data_rw      = 1'b0;
    data_cs      = 1'b0;
    data_address = BASE_W;
    gpio         = 13'h1FFF;
    tb_drv       = 1'b0;
    tb_wdata     = 32'h0;

    vecs[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0,    "w_rise"};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,         32'h1FFF, "rise_trunc"};
    vecs[2]  = '{1'b1, 3'd2, 32'h1234_5678, 32'h0,    "w_fall"};
    vecs[3]  = '{1'b0, 3'd2, 32'h0,         32'h1678, "fall_trunc"};
    vecs[4]  = '{1'b1, 3'd4, 32'h0000_0A5A, 32'h0,    "w_mask"};
    vecs[5]  = '{1'b0, 3'd4, 32'h0,         32'h0A5A, "mask_rw"};
    vecs[6]  = '{1'b1, 3'd5, 32'hABCD_0007, 32'h0,    "w_deb"};
    vecs[7]  = '{1'b0, 3'd5, 32'h0,         32'h0007, "deb_trunc"};
    vecs[8]  = '{1'b1, 3'd0, 32'h0,         32'h0,    "w_value"};
    vecs[9]  = '{1'b0, 3'd0, 32'h0,         32'h1FFF, "value_ro"};
    vecs[10] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0,    "w_off6"};
    vecs[11] = '{1'b0, 3'd6, 32'h0,         32'h0,    "off6_zero"};
    vecs[12] = '{1'b0, 3'd7, 32'h0,         32'h0,    "off7_zero"};
    vecs[13] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0,    "w_pend"};
    vecs[14] = '{1'b0, 3'd3, 32'h0,         32'h0,    "pend_idle"};
    vecs[15] = '{1'b1, 3'd1, 32'h0,         32'h0,    "w_rise0"};
    vecs[16] = '{1'b1, 3'd2, 32'h0,         32'h0,    "w_fall0"};
    vecs[17] = '{1'b1, 3'd4, 32'h0,         32'h0,    "w_mask0"};
    vecs[18] = '{1'b0, 3'd1, 32'h0,         32'h0,    "rise_clr"};
    vecs[19] = '{1'b0, 3'd2, 32'h0,         32'h0,    "fall_clr"};
    vecs[20] = '{1'b0, 3'd4, 32'h0,         32'h0,    "mask_clr"};

    // Reset values, read while reset is held.
    #2;
    check("rst_irq", 32'(irq), 32'h0);
    rd_check("rst_rise", 3'd1, 32'h0);
    rd_check("rst_fall", 3'd2, 32'h0);
    rd_check("rst_pend", 3'd3, 32'h0);
    rd_check("rst_mask", 3'd4, 32'h0);
    rd_check("rst_deb",  3'd5, 32'd1000);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    step(1005);
    rd_check("post_rst_value", 3'd0, 32'h1FFF);
    rd_check("post_rst_pend",  3'd3, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);

    // Register access table.
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].off, vecs[i].wdata);
      end else begin
        rd_check(vecs[i].name, vecs[i].off, vecs[i].exp);
      end
    end

    // Debounce latency with D=3: stable moves on edge k+5.
    @(negedge cpu_clk);
    bus_write(3'd5, 32'd3);
    gpio = 13'h0;
    step(10);
    bus_write(3'd1, 32'h1);
    bus_write(3'd4, 32'h1);
    rd_check("lat_pend0", 3'd3, 32'h0);
    gpio[0] = 1'b1;
    step(5);
    rd_check("lat_before", 3'd0, 32'h0);
    check("lat_irq_before", 32'(irq), 32'h0);
    step(1);
    rd_check("lat_value", 3'd0, 32'h1);
    rd_check("lat_pend", 3'd3, 32'h1);
    check("lat_irq", 32'(irq), 32'h1);
    @(negedge cpu_clk);
    bus_write(3'd3, 32'h1);
    rd_check("clr_pend", 3'd3, 32'h0);
    check("clr_irq", 32'(irq), 32'h0);

    // Glitch rejection on pin 2, then a 4-cycle pulse that passes.
    bus_write(3'd1, 32'h5);
    gpio[2] = 1'b1;
    step(3);
    gpio[2] = 1'b0;
    step(10);
    rd_check("glitch_value", 3'd0, 32'h1);
    rd_check("glitch_pend", 3'd3, 32'h0);
    @(negedge cpu_clk);
    gpio[2] = 1'b1;
    step(4);
    gpio[2] = 1'b0;
    step(1);
    rd_check("pulse_pre", 3'd0, 32'h1);
    step(1);
    rd_check("pulse_rise", 3'd0, 32'h5);
    rd_check("pulse_pend", 3'd3, 32'h4);
    step(3);
    rd_check("pulse_hold", 3'd0, 32'h5);
    step(1);
    rd_check("pulse_fall", 3'd0, 32'h1);

    // W1C and set-wins collision.
    @(negedge cpu_clk);
    bus_write(3'd2, 32'h1);
    gpio[0] = 1'b0;
    step(8);
    rd_check("w1c_pend5", 3'd3, 32'h5);
    check("w1c_irq_on", 32'(irq), 32'h1);
    @(negedge cpu_clk);
    bus_write(3'd3, 32'h1);
    rd_check("w1c_pend4", 3'd3, 32'h4);
    check("w1c_irq_off", 32'(irq), 32'h0);
    @(negedge cpu_clk);
    bus_write(3'd4, 32'h4);
    check("w1c_irq_mask", 32'(irq), 32'h1);
    gpio[2] = 1'b1;
    step(5);
    bus_write(3'd3, 32'h4);
    rd_check("coll_pend", 3'd3, 32'h4);
    rd_check("coll_value", 3'd0, 32'h4);
    check("coll_irq", 32'(irq), 32'h1);
    @(negedge cpu_clk);
    bus_write(3'd3, 32'h4);
    rd_check("coll_clear", 3'd3, 32'h0);
    check("coll_irq_off", 32'(irq), 32'h0);

    // Masked falling event on pin 5, then unmasking raises irq.
    bus_write(3'd4, 32'h0);
    bus_write(3'd2, 32'h20);
    gpio[5] = 1'b1;
    step(8);
    rd_check("mask_pend0", 3'd3, 32'h0);
    @(negedge cpu_clk);
    gpio[5] = 1'b0;
    step(8);
    rd_check("mask_pend", 3'd3, 32'h20);
    check("mask_irq_off", 32'(irq), 32'h0);
    @(negedge cpu_clk);
    bus_write(3'd4, 32'h20);
    check("mask_irq_on", 32'(irq), 32'h1);

    // Bus stays released outside selected reads; VALUE ignores writes.
    @(negedge cpu_clk);
    quiet_probe("hyg_base8", 1'b1, 1'b0, BASE_W + 30'd8);
    quiet_probe("hyg_base9", 1'b1, 1'b0, BASE_W + 30'd9);
    quiet_probe("hyg_nocs", 1'b0, 1'b0, BASE_W);
    quiet_probe("hyg_write", 1'b1, 1'b1, BASE_W + 30'd1);
    @(negedge cpu_clk);
    bus_write(3'd0, 32'h0);
    rd_check("value_nowrite", 3'd0, 32'h4);
    check("irq_kept", 32'(irq), 32'h1);

    // Asynchronous reset clears irq without a clock edge.
    @(negedge cpu_clk);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    rd_check("async_deb", 3'd5, 32'd1000);
    rd_check("async_pend", 3'd3, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
